// File: rtl/transaction_forwarder_if.sv
// Valid/ready master port carrying one forwarded queue word
// and its source queue id toward memory.
interface transaction_forwarder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ID_WIDTH-1:0]   m_id;
  logic                  m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_id,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_id,
    output m_ready
  );
endinterface

// File: rtl/transaction_forwarder.sv
// MemorEDF downstream stage: pops the scheduled queue head, forwards it
// on a valid/ready port and returns a one-cycle consumed pulse.
module transaction_forwarder #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_SIZE     = 32,
  localparam int IW = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic [IW-1:0] i_id,
  input  logic [NUMBER_OF_QUEUES-1:0] i_empty,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] i_queue_data,
  output logic [NUMBER_OF_QUEUES-1:0] o_pop,
  output logic o_consumed,
  output logic o_busy,
  output logic [NUMBER_OF_QUEUES-1:0][COUNTER_SIZE-1:0] o_forwarded_count,
  output logic o_drop_error,
  transaction_forwarder_if.master m
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t r_state;
  logic [IW-1:0] r_id_q;
  logic r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [IW-1:0] r_m_id;
  logic r_consumed;
  logic r_drop_error;
  logic [NUMBER_OF_QUEUES-1:0][COUNTER_SIZE-1:0] r_count;
  logic w_head_empty;

  assign w_head_empty = i_empty[r_id_q];

  // Pop must land in the same cycle the head word is captured.
  always_comb begin
    o_pop = '0;
    if (r_state == CAPTURE) begin
      o_pop[r_id_q] = ~w_head_empty;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_id_q       <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_id       <= '0;
      r_consumed   <= 1'b0;
      r_drop_error <= 1'b0;
      r_count      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_id_q  <= i_id;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!w_head_empty) begin
            r_m_data  <= i_queue_data[r_id_q];
            r_m_id    <= r_id_q;
            r_m_valid <= 1'b1;
            r_state   <= SEND;
          end else begin
            // Empty head still releases the scheduler to avoid deadlock.
            r_drop_error <= 1'b1;
            r_consumed   <= 1'b1;
            r_state      <= DONE;
          end
        end
        SEND: begin
          if (m.m_ready) begin
            r_m_valid <= 1'b0;
            r_count[r_id_q] <=
              r_count[r_id_q] + COUNTER_SIZE'(1);
            r_consumed <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_consumed <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m.m_valid         = r_m_valid;
  assign m.m_data          = r_m_data;
  assign m.m_id            = r_m_id;
  assign o_consumed        = r_consumed;
  assign o_busy            = (r_state != IDLE);
  assign o_drop_error      = r_drop_error;
  assign o_forwarded_count = r_count;

endmodule
